byte_serial_adder: RTL and testbench

- Multi-byte sequencer wrapped around the 8-bit carry-lookahead adder; directly upstream of it, and also the consumer of its outputs.
- Accepts wide operands through a valid/ready handshake.
- Feeds the adder one byte per cycle, least-significant byte first, and latches the adder's carry out as the next byte's carry in.
- Assembles the wide result and reports it with carry, signed-overflow and zero flags. The adder stays combinational and external; this block drives its operand and carry pins and samples its sum and carry-out pins.

---
 rtl/byte_serial_adder.sv | 167 ++++++++++++++++
 tb/tb_byte_serial_adder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_adder.sv
// ---------------------------------------------------------------------------
// byte_serial_adder
//
// Purpose:
//   Sequences a wide add or subtract through an external, purely
//   combinational 8-bit carry-lookahead adder. Each RUN cycle sends one byte
//   to the adder, least-significant byte first. The adder's carry out is
//   kept as the carry in for the next byte. After the last byte, the block
//   presents the assembled result with carry, signed-overflow and zero flags.
//
// Parameters:
//   NUM_BYTES  operand width in bytes (2..16); W = 8*NUM_BYTES
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready   operand handshake (in_ready high only in IDLE)
//   op_a, op_b           W-bit operands
//   carry_in             external carry (ignored when sub=1)
//   sub                  1 = A - B, computed as A + ~B + 1
//   cla_in1, cla_in2     byte operands driven to the external adder
//   cla_cin              carry driven to the external adder
//   cla_sum, cla_cout    sum byte and carry sampled from the external adder
//   out_valid, out_ready result handshake
//   result               W-bit sum, modulo 2^W
//   carry_out            final carry (for subtract, 1 = no borrow)
//   overflow             two's-complement overflow
//   zero                 result == 0
// ---------------------------------------------------------------------------
module byte_serial_adder #(
  parameter  int NUM_BYTES = 4,
  localparam int W         = 8 * NUM_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         carry_in,
  input  logic         sub,
  output logic [7:0]   cla_in1,
  output logic [7:0]   cla_in2,
  output logic         cla_cin,
  input  logic [7:0]   cla_sum,
  input  logic         cla_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow,
  output logic         zero
);

  localparam int IDX_W = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     result_merged;
  logic             last_byte;

  assign last_byte = (idx == IDX_W'(NUM_BYTES - 1));

  // The result with the byte currently being produced by the adder already
  // written in. The zero flag is computed from this value, so the flag is
  // ready on the same edge that stores the final byte.
  always_comb begin
    result_merged = result;
    result_merged[idx*8 +: 8] = cla_sum;
  end

  // State register. Because the reset is asynchronous, asserting it
  // mid-operation drops straight back to IDLE and abandons the partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake/adder outputs. Outside RUN, the adder
  // pins are held at zero so the external adder sees quiescent inputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    cla_in1    = 8'h00;
    cla_in2    = 8'h00;
    cla_cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        cla_in1 = a_reg[idx*8 +: 8];
        cla_in2 = b_reg[idx*8 +: 8];
        cla_cin = carry_reg;
        if (last_byte) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. Operands are captured on accept, with B already inverted for
  // subtraction so RUN only ever adds. Each RUN edge stores one sum byte
  // and the carry for the next byte. The flags are registered on the edge
  // that stores the last byte, and they then hold through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= sub ? ~op_b : op_b;
            carry_reg <= sub ? 1'b1 : carry_in;
            idx       <= '0;
          end
        end
        RUN: begin
          result    <= result_merged;
          carry_reg <= cla_cout;
          idx       <= last_byte ? '0 : idx + 1'b1;
          if (last_byte) begin
            carry_out <= cla_cout;
            overflow  <= (a_reg[W-1] == b_reg[W-1]) && (cla_sum[7] != a_reg[W-1]);
            zero      <= (result_merged == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_byte_serial_adder
//
// Purpose:
//   Self-checking bench for byte_serial_adder with NUM_BYTES=4. It stands in
//   for the external 8-bit adder with a one-line behavioural sum. Expected
//   results, flags and per-byte carries come from whole-word arithmetic.
// ---------------------------------------------------------------------------
module tb_byte_serial_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         carry_in;
  logic         sub;
  logic [7:0]   cla_in1;
  logic [7:0]   cla_in2;
  logic         cla_cin;
  logic [7:0]   cla_sum;
  logic         cla_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external combinational 8-bit adder.
  assign {cla_cout, cla_sum} = 9'(cla_in1) + 9'(cla_in2) + 9'(cla_cin);

  byte_serial_adder #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
    .sub       (sub),
    .cla_in1   (cla_in1),
    .cla_in2   (cla_in2),
    .cla_cin   (cla_cin),
    .cla_sum   (cla_sum),
    .cla_cout  (cla_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Carry into byte k: the carry out of the low 8*k bits of the whole-word sum.
  function automatic logic carryInto(input logic [W-1:0] a, input logic [W-1:0] beff,
                                     input logic c0, input int k);
    longint unsigned mask;
    longint unsigned s;
    mask = (64'd1 << (8 * k)) - 64'd1;
    s    = (longint'(a) & mask) + (longint'(beff) & mask) + longint'(c0);
    return s[8*k];
  endfunction

  // Runs one complete operation and checks it. It verifies the handshake,
  // the latency, the byte/carry sequence sent to the adder, and the result
  // and flags. The result is then held under backpressure for 'hold'
  // cycles. When probeIgnore is set, it also offers a competing operand
  // during that time.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, input logic ci,
                               input int hold, input bit probeIgnore);
    logic [W-1:0] beff;
    logic         c0;
    logic [W:0]   full;
    logic [W-1:0] expRes;
    logic         expOv;
    logic [7:0]   seenIn1 [NB];
    logic [7:0]   seenIn2 [NB];
    logic         seenCin [NB];
    int           cycles;

    beff   = s ? ~b : b;
    c0     = s ? 1'b1 : ci;
    full   = {1'b0, a} + {1'b0, beff} + (W+1)'(c0);
    expRes = full[W-1:0];
    expOv  = (a[W-1] == beff[W-1]) && (expRes[W-1] != a[W-1]);

    @(negedge clk);
    checkOutput("in_ready_idle", in_ready, 1);
    op_a     = a;
    op_b     = b;
    sub      = s;
    carry_in = ci;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = ~a;
    op_b     = $urandom;
    sub      = ~s;
    carry_in = ~ci;

    cycles = 0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (cycles <= NB) begin
        seenIn1[cycles-1] = cla_in1;
        seenIn2[cycles-1] = cla_in2;
        seenCin[cycles-1] = cla_cin;
      end
      if (out_valid) break;
    end
    checkOutput("latency", cycles, NB + 1);

    for (int k = 0; k < NB; k++) begin
      checkOutput($sformatf("cla_in1[%0d]", k), seenIn1[k], a[k*8 +: 8]);
      checkOutput($sformatf("cla_in2[%0d]", k), seenIn2[k], beff[k*8 +: 8]);
      checkOutput($sformatf("cla_cin[%0d]", k), seenCin[k], carryInto(a, beff, c0, k));
    end

    checkOutput("result", result, expRes);
    checkOutput("carry_out", carry_out, full[W]);
    checkOutput("overflow", overflow, expOv);
    checkOutput("zero", zero, expRes == '0);
    checkOutput("in_ready_done", in_ready, 0);
    checkOutput("cla_quiet_done", {cla_in1, cla_in2, cla_cin}, 0);

    for (int h = 0; h < hold; h++) begin
      if (probeIgnore) begin
        in_valid = 1'b1;
        op_a     = $urandom;
        op_b     = $urandom;
      end
      @(negedge clk);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_ready", in_ready, 0);
      checkOutput("hold_result", result, expRes);
      checkOutput("hold_flags", {carry_out, overflow, zero}, {full[W], expOv, expRes == '0});
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("release_valid", out_valid, 0);
    checkOutput("release_ready", in_ready, 1);
  endtask

  // Directed cases first, then a mid-operation reset, then random traffic.
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    carry_in  = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_flags", {carry_out, overflow, zero}, 0);
    checkOutput("rst_cla", {cla_in1, cla_in2, cla_cin}, 0);
    rst = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1, 1'b0);
    applyStimulus(32'h00000005, 32'h00000007, 1'b1, 1'b1, 0, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 1'b1, 0, 1'b0);
    applyStimulus(32'h00000000, 32'h00000000, 1'b1, 1'b0, 0, 1'b0);
    $display("[TB] backpressure");
    applyStimulus(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1, 10, 1'b1);

    $display("[TB] reset during RUN");
    @(negedge clk);
    op_a     = 32'hAAAA5555;
    op_b     = 32'h5555AAAB;
    sub      = 1'b0;
    carry_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_result", result, 0);
    checkOutput("midrst_flags", {carry_out, overflow, zero}, 0);
    checkOutput("midrst_cla", {cla_in1, cla_in2, cla_cin}, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (NB + 3) @(negedge clk);
    checkOutput("midrst_no_valid", out_valid, 0);
    applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("post_rst_sum", result, 32'h23456789);

    $display("[TB] random cases");
    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ~ra;
        1: rb = ra;
        2: ra = {1'b0, {(W-1){1'b1}}};
        default: begin
        end
      endcase
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
